// File: rtl/fpu_ss_mem_responder.sv
// Memory responder for the FPU coprocessor interface: turns one load/store request into
// OBI word transactions. Define FPU_SS_MEM_DW_SPLIT_EN to run DoubleWords as two beats.
module fpu_ss_mem_responder #(
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_valid_i,
  output logic                mem_ready_o,
  input  logic [ID_WIDTH-1:0] mem_id_i,
  input  logic [31:0]         mem_addr_i,
  input  logic                mem_we_i,
  input  logic [1:0]          mem_size_i,
  input  logic [63:0]         mem_wdata_i,
  output logic                mem_result_valid_o,
  output logic [ID_WIDTH-1:0] mem_result_id_o,
  output logic [63:0]         mem_result_rdata_o,
  output logic                mem_result_err_o,
  output logic                data_req_o,
  input  logic                data_gnt_i,
  output logic [31:0]         data_addr_o,
  output logic                data_we_o,
  output logic [3:0]          data_be_o,
  output logic [31:0]         data_wdata_o,
  input  logic                data_rvalid_i,
  input  logic [31:0]         data_rdata_i,
  input  logic                data_err_i
);

  // state | meaning
  // IDLE  | ready for a request
  // ADDR  | data_req_o held until grant
  // DATA  | waiting for rvalid of the granted beat
  // RESP  | one-cycle result pulse
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_D = 2'b11;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [31:0]           addr_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic [63:0]           wdata_q;
  logic [63:0]           rdata_q;
  logic                  err_q;

  logic                  handshake;
  logic                  misaligned;
  logic                  dw_unsupported;
  logic                  req_bad;
  logic                  beat_sel;
  logic                  last_beat;
  logic [4:0]            shamt;
  logic [31:0]           rdata_shifted;
  logic [31:0]           load_word;
  logic [3:0]            be;
  logic                  rvalid_in_data;

  assign handshake      = mem_valid_i & mem_ready_o;
  assign shamt          = {addr_q[1:0], 3'b000};
  assign rdata_shifted  = data_rdata_i >> shamt;
  assign rvalid_in_data = (state_q == DATA) & data_rvalid_i;

  always_comb begin
    misaligned = 1'b0;
    case (mem_size_i)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = mem_addr_i[0];
      SZ_D:    misaligned = |mem_addr_i[2:0];
      default: misaligned = |mem_addr_i[1:0];
    endcase
  end

`ifdef FPU_SS_MEM_DW_SPLIT_EN
  logic beat_q;

  assign dw_unsupported = 1'b0;
  assign beat_sel       = beat_q;
  assign last_beat      = (size_q != SZ_D) | beat_q;

  // Beat counter only ever advances after a clean beat 0 of a DoubleWord.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == IDLE) begin
      beat_q <= 1'b0;
    end else if (rvalid_in_data && !data_err_i && !last_beat) begin
      beat_q <= 1'b1;
    end
  end
`else
  logic unused_wdata_hi;

  assign dw_unsupported  = (mem_size_i == SZ_D);
  assign beat_sel        = 1'b0;
  assign last_beat       = 1'b1;
  assign unused_wdata_hi = ^wdata_q[63:32];
`endif

  assign req_bad = misaligned | dw_unsupported;

  always_comb begin
    load_word = rdata_shifted;
    case (size_q)
      SZ_B:    load_word = {24'b0, rdata_shifted[7:0]};
      SZ_H:    load_word = {16'b0, rdata_shifted[15:0]};
      default: load_word = rdata_shifted;
    endcase
  end

  always_comb begin
    be = 4'b1111;
    case (size_q)
      SZ_B:    be = 4'b0001 << addr_q[1:0];
      SZ_H:    be = 4'b0011 << addr_q[1:0];
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (handshake) state_d = req_bad ? RESP : ADDR;
      ADDR: if (data_gnt_i) state_d = DATA;
      DATA: if (data_rvalid_i) state_d = (data_err_i || last_beat) ? RESP : ADDR;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_ready_o        = 1'b0;
    mem_result_valid_o = 1'b0;
    mem_result_id_o    = '0;
    mem_result_rdata_o = '0;
    mem_result_err_o   = 1'b0;
    data_req_o         = 1'b0;
    data_addr_o        = '0;
    data_we_o          = 1'b0;
    data_be_o          = '0;
    data_wdata_o       = '0;
    case (state_q)
      IDLE: mem_ready_o = ~rst_i;
      ADDR: begin
        data_req_o   = 1'b1;
        // Second DoubleWord beat lands on addr+4; the access is 8-aligned so bit 2 is free.
        data_addr_o  = {addr_q[31:3], addr_q[2] | beat_sel, 2'b00};
        data_we_o    = we_q;
        data_be_o    = be;
        data_wdata_o = beat_sel ? wdata_q[63:32] : (wdata_q[31:0] << shamt);
      end
      RESP: begin
        mem_result_valid_o = 1'b1;
        mem_result_id_o    = id_q;
        mem_result_rdata_o = rdata_q;
        mem_result_err_o   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q    <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (handshake) begin
        id_q    <= mem_id_i;
        addr_q  <= mem_addr_i;
        we_q    <= mem_we_i;
        size_q  <= mem_size_i;
        wdata_q <= mem_wdata_i;
        rdata_q <= '0;
        err_q   <= req_bad;
      end
      if (rvalid_in_data) begin
        if (data_err_i) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end else if (!we_q) begin
          if (beat_sel) begin
            rdata_q[63:32] <= data_rdata_i;
          end else begin
            rdata_q <= {32'b0, load_word};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_ss_mem_responder.sv
// Directed self-checking bench for fpu_ss_mem_responder; expectations follow the
// FPU_SS_MEM_DW_SPLIT_EN setting of the build.
module tb_fpu_ss_mem_responder;

  localparam int ID_WIDTH = 4;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                mem_valid_i;
  logic                mem_ready_o;
  logic [ID_WIDTH-1:0] mem_id_i;
  logic [31:0]         mem_addr_i;
  logic                mem_we_i;
  logic [1:0]          mem_size_i;
  logic [63:0]         mem_wdata_i;
  logic                mem_result_valid_o;
  logic [ID_WIDTH-1:0] mem_result_id_o;
  logic [63:0]         mem_result_rdata_o;
  logic                mem_result_err_o;
  logic                data_req_o;
  logic                data_gnt_i;
  logic [31:0]         data_addr_o;
  logic                data_we_o;
  logic [3:0]          data_be_o;
  logic [31:0]         data_wdata_o;
  logic                data_rvalid_i;
  logic [31:0]         data_rdata_i;
  logic                data_err_i;

  int n_assert = 0;
  int n_fail   = 0;

  fpu_ss_mem_responder #(.ID_WIDTH(ID_WIDTH)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .mem_valid_i        (mem_valid_i),
    .mem_ready_o        (mem_ready_o),
    .mem_id_i           (mem_id_i),
    .mem_addr_i         (mem_addr_i),
    .mem_we_i           (mem_we_i),
    .mem_size_i         (mem_size_i),
    .mem_wdata_i        (mem_wdata_i),
    .mem_result_valid_o (mem_result_valid_o),
    .mem_result_id_o    (mem_result_id_o),
    .mem_result_rdata_o (mem_result_rdata_o),
    .mem_result_err_o   (mem_result_err_o),
    .data_req_o         (data_req_o),
    .data_gnt_i         (data_gnt_i),
    .data_addr_o        (data_addr_o),
    .data_we_o          (data_we_o),
    .data_be_o          (data_be_o),
    .data_wdata_o       (data_wdata_o),
    .data_rvalid_i      (data_rvalid_i),
    .data_rdata_i       (data_rdata_i),
    .data_err_i         (data_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request for one cycle; returns in the cycle after the handshake.
  task automatic start(input string tag, input logic [3:0] id, input logic [31:0] addr,
                       input logic we, input logic [1:0] size, input logic [63:0] wdata);
    check({tag, "/ready"}, 64'(mem_ready_o), 64'd1);
    mem_valid_i = 1'b1;
    mem_id_i    = id;
    mem_addr_i  = addr;
    mem_we_i    = we;
    mem_size_i  = size;
    mem_wdata_i = wdata;
    cyc();
    mem_valid_i = 1'b0;
    mem_addr_i  = 32'hFFFF_FFFF;
    mem_wdata_i = '1;
  endtask

  task automatic beat(input string tag, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                      input logic exp_we, input logic [31:0] exp_wdata, input int stall,
                      input logic [31:0] rdata, input logic err);
    for (int i = 0; i < stall; i++) begin
      check({tag, "/stall_req"}, 64'(data_req_o), 64'd1);
      check({tag, "/stall_addr"}, 64'(data_addr_o), 64'(exp_addr));
      check({tag, "/stall_ready"}, 64'(mem_ready_o), 64'd0);
      cyc();
    end
    check({tag, "/req"}, 64'(data_req_o), 64'd1);
    check({tag, "/addr"}, 64'(data_addr_o), 64'(exp_addr));
    check({tag, "/be"}, 64'(data_be_o), 64'(exp_be));
    check({tag, "/we"}, 64'(data_we_o), 64'(exp_we));
    check({tag, "/wdata"}, 64'(data_wdata_o), 64'(exp_wdata));
    data_gnt_i = 1'b1;
    cyc();
    data_gnt_i = 1'b0;
    check({tag, "/data_noreq"}, 64'(data_req_o), 64'd0);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    data_err_i    = err;
    cyc();
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = 32'h0;
  endtask

  task automatic result(input string tag, input logic [3:0] id, input logic [63:0] rdata,
                        input logic err);
    check({tag, "/rvalid"}, 64'(mem_result_valid_o), 64'd1);
    check({tag, "/rid"}, 64'(mem_result_id_o), 64'(id));
    check({tag, "/rdata"}, mem_result_rdata_o, rdata);
    check({tag, "/rerr"}, 64'(mem_result_err_o), 64'(err));
    check({tag, "/rreq"}, 64'(data_req_o), 64'd0);
    cyc();
    check({tag, "/pulse_end"}, 64'(mem_result_valid_o), 64'd0);
    check({tag, "/idle_ready"}, 64'(mem_ready_o), 64'd1);
  endtask

  initial begin
    rst_i         = 1'b1;
    mem_valid_i   = 1'b0;
    mem_id_i      = '0;
    mem_addr_i    = '0;
    mem_we_i      = 1'b0;
    mem_size_i    = '0;
    mem_wdata_i   = '0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    data_err_i    = 1'b0;

    cyc();
    cyc();
    check("rst/ready", 64'(mem_ready_o), 64'd0);
    check("rst/req", 64'(data_req_o), 64'd0);
    check("rst/rvalid", 64'(mem_result_valid_o), 64'd0);
    check("rst/be", 64'(data_be_o), 64'd0);
    rst_i = 1'b0;
    cyc();
    check("rst/ready_after", 64'(mem_ready_o), 64'd1);

    // Word load, zero-wait grant/rvalid: result three cycles after the handshake.
    start("wld", 4'd3, 32'h100, 1'b0, 2'b10, 64'h0);
    beat("wld", 32'h100, 4'b1111, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    result("wld", 4'd3, 64'h0000_0000_DEAD_BEEF, 1'b0);

    start("bst", 4'd5, 32'h203, 1'b1, 2'b00, 64'hA5);
    beat("bst", 32'h200, 4'b1000, 1'b1, 32'hA500_0000, 0, 32'h1234_5678, 1'b0);
    result("bst", 4'd5, 64'h0, 1'b0);

    start("bld", 4'd6, 32'h102, 1'b0, 2'b00, 64'h0);
    beat("bld", 32'h100, 4'b0100, 1'b0, 32'h0, 0, 32'hAABB_CCDD, 1'b0);
    result("bld", 4'd6, 64'hBB, 1'b0);

    start("hld", 4'd2, 32'h102, 1'b0, 2'b01, 64'h0);
    beat("hld", 32'h100, 4'b1100, 1'b0, 32'h0, 0, 32'hAABB_CCDD, 1'b0);
    result("hld", 4'd2, 64'hAABB, 1'b0);

    start("hmis", 4'd7, 32'h101, 1'b0, 2'b01, 64'h0);
    result("hmis", 4'd7, 64'h0, 1'b1);

    // Store held off by five cycles of no grant.
    start("wst", 4'd8, 32'h104, 1'b1, 2'b10, 64'h0123_4567_CAFE_F00D);
    beat("wst", 32'h104, 4'b1111, 1'b1, 32'hCAFE_F00D, 5, 32'h0, 1'b0);
    result("wst", 4'd8, 64'h0, 1'b0);

    start("wmis", 4'd9, 32'h102, 1'b0, 2'b10, 64'h0);
    result("wmis", 4'd9, 64'h0, 1'b1);

`ifdef FPU_SS_MEM_DW_SPLIT_EN
    start("dld", 4'd10, 32'h300, 1'b0, 2'b11, 64'h0);
    beat("dld0", 32'h300, 4'b1111, 1'b0, 32'h0, 0, 32'h1111_1111, 1'b0);
    beat("dld1", 32'h304, 4'b1111, 1'b0, 32'h0, 0, 32'h2222_2222, 1'b0);
    result("dld", 4'd10, 64'h2222_2222_1111_1111, 1'b0);

    start("dst", 4'd11, 32'h308, 1'b1, 2'b11, 64'hAAAA_BBBB_CCCC_DDDD);
    beat("dst0", 32'h308, 4'b1111, 1'b1, 32'hCCCC_DDDD, 1, 32'h0, 1'b0);
    beat("dst1", 32'h30C, 4'b1111, 1'b1, 32'hAAAA_BBBB, 0, 32'h0, 1'b0);
    result("dst", 4'd11, 64'h0, 1'b0);

    start("derr", 4'd12, 32'h310, 1'b0, 2'b11, 64'h0);
    beat("derr", 32'h310, 4'b1111, 1'b0, 32'h0, 0, 32'h5555_5555, 1'b1);
    result("derr", 4'd12, 64'h0, 1'b1);

    start("dmis", 4'd1, 32'h304, 1'b0, 2'b11, 64'h0);
    result("dmis", 4'd1, 64'h0, 1'b1);
`else
    start("dld", 4'd10, 32'h300, 1'b0, 2'b11, 64'h0);
    result("dld", 4'd10, 64'h0, 1'b1);
`endif

    start("werr", 4'd13, 32'h200, 1'b0, 2'b10, 64'h0);
    beat("werr", 32'h200, 4'b1111, 1'b0, 32'h0, 0, 32'h7777_7777, 1'b1);
    result("werr", 4'd13, 64'h0, 1'b1);

    // Reset while waiting for rvalid, then a stray rvalid afterwards.
    start("rmid", 4'd14, 32'h400, 1'b0, 2'b10, 64'h0);
    check("rmid/req", 64'(data_req_o), 64'd1);
    data_gnt_i = 1'b1;
    cyc();
    data_gnt_i = 1'b0;
    check("rmid/in_data", 64'(data_req_o), 64'd0);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    #1;
    check("rmid/no_result", 64'(mem_result_valid_o), 64'd0);
    check("rmid/ready", 64'(mem_ready_o), 64'd1);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h9999_9999;
    cyc();
    data_rvalid_i = 1'b0;
    check("rmid/late_rvalid", 64'(mem_result_valid_o), 64'd0);
    check("rmid/late_req", 64'(data_req_o), 64'd0);
    check("rmid/late_ready", 64'(mem_ready_o), 64'd1);
    cyc();
    check("rmid/still_quiet", 64'(mem_result_valid_o), 64'd0);

    start("post", 4'd15, 32'h500, 1'b0, 2'b10, 64'h0);
    beat("post", 32'h500, 4'b1111, 1'b0, 32'h0, 2, 32'h0BAD_F00D, 1'b0);
    result("post", 4'd15, 64'h0BAD_F00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_ss_mem_responder.md
FPU_SS_MEM_RESPONDER -- requirements
Module: fpu_ss_mem_responder

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 4: width of the coprocessor transaction ID.
REQ-002 The block SHALL have port clk_i, input, 1: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port mem_valid_i, input, 1: the coprocessor memory request is valid.
REQ-005 The block SHALL have port mem_ready_o, output, 1: this block accepts the request.
REQ-006 The block SHALL have port mem_id_i, input, ID_WIDTH: request ID.
REQ-007 The block SHALL have ports mem_addr_i, input, 32 (byte address) and mem_we_i, input, 1 (1 = store).
REQ-008 The block SHALL have port mem_size_i, input, 2: ls_size_e, where 00 = Byte, 01 = HalfWord, 10 = Word, 11 = DoubleWord.
REQ-009 The block SHALL have port mem_wdata_i, input, 64: store data, right-aligned.
REQ-010 The block SHALL have ports mem_result_valid_o, output, 1; mem_result_id_o, output, ID_WIDTH; mem_result_rdata_o, output, 64; mem_result_err_o, output, 1.
REQ-011 The block SHALL have an OBI-style data port: data_req_o (out, 1), data_gnt_i (in, 1), data_addr_o (out, 32), data_we_o (out, 1), data_be_o (out, 4), data_wdata_o (out, 32), data_rvalid_i (in, 1), data_rdata_i (in, 32), data_err_i (in, 1).

Function
REQ-012 The FSM SHALL have the states IDLE, ADDR, DATA and RESP; mem_ready_o SHALL be 1 only in IDLE.
REQ-013 On a handshake (mem_valid_i & mem_ready_o), the block SHALL register id, addr, we, size and wdata, then go to ADDR, or to RESP with err=1 if the request is misaligned.
REQ-014 Misaligned SHALL mean: HalfWord with addr[0]!=0; Word with addr[1:0]!=0; DoubleWord with addr[2:0]!=0. Byte is never misaligned.
REQ-015 For a misaligned request, the block SHALL issue no data-bus transaction.
REQ-016 In ADDR, data_req_o SHALL be held at 1 with stable address and attributes until data_gnt_i; on grant the block SHALL go to DATA. There SHALL be at most one outstanding bus transaction.
REQ-017 data_addr_o SHALL be {addr[31:2], 2'b00}.
REQ-018 data_be_o SHALL be: Byte 0001 << addr[1:0]; HalfWord 0011 << addr[1:0]; Word and DoubleWord 1111.
REQ-019 Store data SHALL be shifted left by 8*addr[1:0] onto data_wdata_o.
REQ-020 In DATA, on data_rvalid_i the block SHALL take the load data as data_rdata_i >> 8*addr[1:0], masked to the access size and zero-extended to 64 bits; NaN-boxing is the FPU's job.
REQ-021 After data_rvalid_i in DATA, the block SHALL go to RESP unless a second DoubleWord beat is pending (see REQ-028).
REQ-022 If data_err_i is 1 with data_rvalid_i, the block SHALL set err=1, skip any remaining beat and go to RESP.
REQ-023 In RESP, mem_result_valid_o SHALL be 1 for exactly one cycle with the registered id, rdata (0 for stores and errors) and err; the block then returns to IDLE. There is no result backpressure.
REQ-024 Minimum latency: handshake in cycle T, data_req_o in T+1; with same-cycle grant and rvalid in T+2, the result is valid in T+3.
REQ-025 A misaligned request accepted in cycle T SHALL produce its result in T+1.
REQ-026 data_rvalid_i outside DATA SHALL be ignored.

Reset
REQ-027 While rst_i=1 at a clock edge, the FSM SHALL go to IDLE and the beat counter, error flag and all registered request fields SHALL clear.
  - All outputs SHALL be 0, except mem_ready_o, which is 1 from the first cycle after reset deasserts.
  - A reset mid-operation SHALL abandon the transaction with no result; a late rvalid is dropped per REQ-026.

Configuration
REQ-028 With macro FPU_SS_MEM_DW_SPLIT_EN defined, an aligned DoubleWord SHALL run as two word beats:
  - beat 0: addr and wdata[31:0], loading rdata[31:0];
  - beat 1: addr+4 and wdata[63:32], loading rdata[63:32];
  - flow: DATA -> ADDR -> DATA -> RESP;
  - the 1-bit beat counter clears in IDLE.
REQ-029 With FPU_SS_MEM_DW_SPLIT_EN undefined, any DoubleWord request SHALL be treated as an error:
  - result err=1 in T+1 with no bus traffic;
  - no beat counter is implemented.

Verification
REQ-030 Word load: addr 0x100, rdata 0xDEADBEEF, grant and rvalid with no wait -> data_be_o=1111, result rdata 0x00000000DEADBEEF, err=0, valid in T+3.
REQ-031 Byte store: addr 0x203, wdata 0xA5 -> data_addr_o 0x200, be=1000, wdata[31:24]=0xA5, result err=0, rdata 0.
REQ-032 HalfWord load at 0x101 -> no data_req_o, result err=1 in T+1; the next request is accepted in IDLE.
REQ-033 DoubleWord load at 0x300 with rdata 0x11111111 then 0x22222222:
  - macro defined: addresses 0x300 then 0x304, rdata 0x2222222211111111;
  - macro undefined: err=1, no bus traffic.
REQ-034 Bus error and reset:
  - data_err_i=1 on beat 0 of a DoubleWord -> no second beat, err=1;
  - rst_i asserted in DATA -> IDLE next cycle with no result, and a later rvalid is ignored.
REQ-035 Grant stall: data_gnt_i held low for 5 cycles -> data_req_o and address stable throughout, mem_ready_o=0.
